// File: rtl/matrix_pkg.sv
// Shared HUB75 definitions: bus widths, rgb bit positions, rx FSM states and the plane-wrap helper.
package matrix_pkg;
  localparam int HUB75_RGB_W = 6;
  localparam int PLANE_W     = 3;

  // Bit positions inside the {b2,g2,r2,b1,g1,r1} pixel word
  localparam int RGB_R1 = 0;
  localparam int RGB_G1 = 1;
  localparam int RGB_B1 = 2;
  localparam int RGB_R2 = 3;
  localparam int RGB_G2 = 4;
  localparam int RGB_B2 = 5;

  typedef enum logic {RX_IDLE, RX_DRAIN} rx_state_e;

  function automatic logic [PLANE_W-1:0] next_plane(input logic [PLANE_W-1:0] cur,
                                                    input logic [PLANE_W-1:0] last);
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction
endpackage

// File: rtl/matrix_rx_if.sv
// Framebuffer write port: one pixel word per valid&&ready.
interface matrix_rx_if #(
  parameter int ROW_WIDTH = 4,
  parameter int COL_WIDTH = 6
) ();
  import matrix_pkg::*;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [ROW_WIDTH-1:0]   wr_row;
  logic [COL_WIDTH-1:0]   wr_col;
  logic [PLANE_W-1:0]     wr_plane;
  logic [HUB75_RGB_W-1:0] wr_data;

  modport master (output wr_valid, wr_row, wr_col, wr_plane, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_row, wr_col, wr_plane, wr_data, output wr_ready);
endinterface

// File: rtl/matrix_rx_sync.sv
// Synchroniser for one async control line, with rise/fall pulses taken from the last stage.
module matrix_rx_sync #(
  parameter int STAGES = 2  // must be >= 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/matrix_rx.sv
// HUB75 sink: rebuilds latched rows from oversampled panel lines and streams them out column by column.
// Optional MATRIX_RX_OE_MEASURE_EN adds the oe_cycles OE-high width measurement.
module matrix_rx
  import matrix_pkg::*;
#(
  parameter int COLUMNS     = 64,
  parameter int COL_WIDTH   = 6,
  parameter int ROW_WIDTH   = 4,
  parameter int PLANES      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   hub_clk,
  input  logic                   hub_lat,
  input  logic                   hub_oe,
  input  logic [ROW_WIDTH-1:0]   hub_row,
  input  logic [HUB75_RGB_W-1:0] hub_rgb,
  matrix_rx_if.master            wr,
  output logic                   err_count,
  output logic                   err_overrun,
  input  logic                   clear_err
`ifdef MATRIX_RX_OE_MEASURE_EN
  ,
  output logic [15:0]            oe_cycles
`endif
);
  localparam int CTL_CLK = 0;
  localparam int CTL_LAT = 1;
  localparam int CTL_OE  = 2;
  localparam int NUM_CTL = 3;
  localparam int DAT_W   = ROW_WIDTH + HUB75_RGB_W;
  localparam logic [COL_WIDTH:0]   K_FULL     = (COL_WIDTH+1)'(COLUMNS);
  localparam logic [COL_WIDTH-1:0] COL_LAST   = COL_WIDTH'(COLUMNS-1);
  localparam logic [PLANE_W-1:0]   PLANE_LAST = PLANE_W'(PLANES-1);

  logic [NUM_CTL-1:0] ctl_in, ctl_q, ctl_rise, ctl_fall;
  assign ctl_in = {hub_oe, hub_lat, hub_clk};

  matrix_rx_sync #(.STAGES(SYNC_STAGES)) u_ctl_sync [NUM_CTL-1:0] (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (ctl_in),
    .q      (ctl_q),
    .rise   (ctl_rise),
    .fall   (ctl_fall)
  );

  // Row/rgb use the same depth as the control chains so data lines up with the clk edge.
  logic [SYNC_STAGES-1:0][DAT_W-1:0] dat_pipe;
  always_ff @(posedge clk_in) begin
    if (reset) dat_pipe <= '0;
    else       dat_pipe <= {dat_pipe[SYNC_STAGES-2:0], {hub_row, hub_rgb}};
  end

  logic [ROW_WIDTH-1:0]   row_s;
  logic [HUB75_RGB_W-1:0] rgb_s;
  logic                   clk_rise, lat_rise;
  assign row_s    = dat_pipe[SYNC_STAGES-1][DAT_W-1:HUB75_RGB_W];
  assign rgb_s    = dat_pipe[SYNC_STAGES-1][HUB75_RGB_W-1:0];
  assign clk_rise = ctl_rise[CTL_CLK];
  assign lat_rise = ctl_rise[CTL_LAT];

  logic [COLUMNS-1:0][HUB75_RGB_W-1:0] shift_buf, shift_nxt, drain_buf;
  logic [COL_WIDTH:0]   k, k_nxt;
  logic                 k_ovf, k_ovf_nxt;
  logic [COL_WIDTH-1:0] pix_col;
  logic [PLANE_W-1:0]   plane, plane_nxt;
  logic [ROW_WIDTH-1:0] last_row;
  logic                 lat_seen;
  logic                 cnt_err_set, ovr_set;
  rx_state_e            state;

  assign pix_col = COL_LAST - k[COL_WIDTH-1:0];

  // Pixel storage is resolved before the latch so a same-cycle clk+lat commits that pixel.
  always_comb begin
    shift_nxt = shift_buf;
    k_nxt     = k;
    k_ovf_nxt = k_ovf;
    if (clk_rise) begin
      if (k != K_FULL) begin
        shift_nxt[pix_col] = rgb_s;
        k_nxt              = k + 1'b1;
      end else begin
        k_ovf_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    plane_nxt = '0;
    if (lat_seen && row_s == last_row) plane_nxt = next_plane(plane, PLANE_LAST);
  end

  assign cnt_err_set = lat_rise && (k_nxt != K_FULL || k_ovf_nxt);
  assign ovr_set     = lat_rise && state == RX_DRAIN;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      shift_buf   <= '0;
      k           <= '0;
      k_ovf       <= 1'b0;
      plane       <= '0;
      last_row    <= '0;
      lat_seen    <= 1'b0;
      err_count   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      shift_buf   <= shift_nxt;
      k           <= lat_rise ? '0 : k_nxt;
      k_ovf       <= ~lat_rise & k_ovf_nxt;
      if (lat_rise) begin
        plane    <= plane_nxt;
        last_row <= row_s;
        lat_seen <= 1'b1;
      end
      err_count   <= cnt_err_set | (err_count & ~clear_err);
      err_overrun <= ovr_set | (err_overrun & ~clear_err);
    end
  end

  logic                   wr_valid_q;
  logic [ROW_WIDTH-1:0]   wr_row_q;
  logic [COL_WIDTH-1:0]   wr_col_q;
  logic [PLANE_W-1:0]     wr_plane_q;
  logic [HUB75_RGB_W-1:0] wr_data_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= RX_IDLE;
      wr_valid_q <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_plane_q <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (lat_rise) begin
            drain_buf  <= shift_nxt;
            state      <= RX_DRAIN;
            wr_valid_q <= 1'b1;
            wr_row_q   <= row_s;
            wr_plane_q <= plane_nxt;
            wr_col_q   <= COL_LAST;
            wr_data_q  <= shift_nxt[COL_LAST];
          end
        end
        RX_DRAIN: begin
          if (wr.wr_ready) begin
            if (wr_col_q == '0) begin
              state      <= RX_IDLE;
              wr_valid_q <= 1'b0;
            end else begin
              wr_col_q  <= wr_col_q - 1'b1;
              wr_data_q <= drain_buf[wr_col_q - 1'b1];
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_row   = wr_row_q;
  assign wr.wr_col   = wr_col_q;
  assign wr.wr_plane = wr_plane_q;
  assign wr.wr_data  = wr_data_q;

`ifdef MATRIX_RX_OE_MEASURE_EN
  logic [15:0] oe_cnt;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      oe_cnt    <= '0;
      oe_cycles <= '0;
    end else if (ctl_fall[CTL_OE]) begin
      oe_cycles <= oe_cnt;
      oe_cnt    <= '0;
    end else if (ctl_q[CTL_OE] && oe_cnt != 16'hFFFF) begin
      oe_cnt <= oe_cnt + 16'd1;
    end
  end
`endif

  // Sync outputs not every build consumes (OE is ignored without the measurement option).
  logic unused_ctl;
  assign unused_ctl = ^{ctl_q, ctl_fall, ctl_rise[CTL_OE]};
endmodule

// File: tb/tb_matrix_rx.sv
// Directed + randomized bench for matrix_rx against a slot/plane reference model.
module tb_matrix_rx;
  import matrix_pkg::*;

  localparam int COLS = 64;

  logic       clk_in = 1'b0, reset = 1'b1;
  logic       hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b0, clear_err = 1'b0;
  logic [3:0] hub_row = '0;
  logic [5:0] hub_rgb = '0;
  logic       err_count, err_overrun;
`ifdef MATRIX_RX_OE_MEASURE_EN
  logic [15:0] oe_cycles;
`endif

  matrix_rx_if wif ();

  matrix_rx dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .hub_clk     (hub_clk),
    .hub_lat     (hub_lat),
    .hub_oe      (hub_oe),
    .hub_row     (hub_row),
    .hub_rgb     (hub_rgb),
    .wr          (wif),
    .err_count   (err_count),
    .err_overrun (err_overrun),
    .clear_err   (clear_err)
`ifdef MATRIX_RX_OE_MEASURE_EN
    ,
    .oe_cycles   (oe_cycles)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] col;
    logic [2:0] plane;
    logic [5:0] data;
  } word_t;

  word_t exp_q[$], got_q[$];
  int    vectors = 0, errors = 0;

  // Reference model: slot k holds the latest k-th pixel since its last latch.
  logic [5:0] shadow [COLS];
  int         m_n;
  logic [2:0] m_plane;
  logic [3:0] m_last;
  bit         m_seen, m_err, m_ovr, rnd_ready;

  always @(posedge clk_in)
    if (!reset && wif.wr_valid && wif.wr_ready)
      got_q.push_back(word_t'({wif.wr_row, wif.wr_col, wif.wr_plane, wif.wr_data}));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
      if (rnd_ready) wif.wr_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) shadow[i] = '0;
    m_n = 0; m_plane = '0; m_last = '0; m_seen = 0; m_err = 0; m_ovr = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic pixel(input logic [5:0] d);
    hub_rgb = d;
    hub_clk = 1'b1;
    tick(2);
    hub_clk = 1'b0;
    tick(2);
    if (m_n < COLS) shadow[m_n] = d;
    m_n++;
  endtask

  task automatic latch(input logic [3:0] row, input bit busy, input bit clr);
    hub_row = row;
    hub_lat = 1'b1;
    tick(2);
    clear_err = clr;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    hub_lat = 1'b0;
    m_err = (m_n != COLS) | (m_err & ~clr);
    m_ovr = busy | (m_ovr & ~clr);
    if (!m_seen)          m_plane = '0;
    else if (row == m_last) m_plane = (m_plane == 3'd5) ? 3'd0 : m_plane + 3'd1;
    else                  m_plane = '0;
    m_seen = 1;
    m_last = row;
    if (!busy)
      for (int c = COLS - 1; c >= 0; c--)
        exp_q.push_back(word_t'{row, 6'(c), m_plane, shadow[COLS-1-c]});
    m_n = 0;
    tick(3);
    chk("err_count", err_count, m_err);
    chk("err_overrun", err_overrun, m_ovr);
  endtask

  task automatic send_row(input logic [3:0] row, input int n, input bit rnd);
    for (int i = 0; i < n; i++) pixel(rnd ? 6'($urandom) : 6'(i % 64));
    latch(row, 1'b0, 1'b0);
  endtask

  task automatic check_words(input string tag);
    int t = 0;
    while ((got_q.size() < exp_q.size() || wif.wr_valid) && t < 3000) begin
      tick(1);
      t++;
    end
    chk({tag, "_drain_done"}, 32'(t < 3000), 32'd1);
    chk({tag, "_word_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    m_err = 0;
    m_ovr = 0;
    chk("clear_count", err_count, 1'b0);
    chk("clear_overrun", err_overrun, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, wif.wr_valid, 1'b0);
    chk({tag, "_row"}, wif.wr_row, 4'd0);
    chk({tag, "_col"}, wif.wr_col, 6'd0);
    chk({tag, "_plane"}, wif.wr_plane, 3'd0);
    chk({tag, "_data"}, wif.wr_data, 6'd0);
    chk({tag, "_err_count"}, err_count, 1'b0);
    chk({tag, "_err_overrun"}, err_overrun, 1'b0);
  endtask

  initial begin
    int g, t;
    wif.wr_ready = 1'b1;
    rnd_ready    = 0;
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_idle_outputs("reset");

    // Counting pattern on row 3
    send_row(4'd3, 64, 1'b0);
    check_words("t1");

    // Plane sequence: seven latches on row 5, then row 6
    repeat (7) send_row(4'd5, 64, 1'b1);
    send_row(4'd6, 64, 1'b1);
    check_words("t2");

    // Random rows from a small set so planes both advance and reset, random backpressure
    rnd_ready = 1;
    repeat (5) send_row(4'($urandom_range(0, 2)), 64, 1'b1);
    rnd_ready    = 0;
    wif.wr_ready = 1'b1;
    check_words("rand");

    // Short, long, and clear-vs-error collision
    send_row(4'd7, 63, 1'b1);
    check_words("short");
    clear();
    send_row(4'd7, 66, 1'b1);
    check_words("long");
    clear();
    latch(4'd7, 1'b0, 1'b1);
    check_words("clr_collide");
    clear();

    // Backpressure hold and latch during drain
    for (int i = 0; i < 64; i++) pixel(6'($urandom));
    latch(4'd9, 1'b0, 1'b0);
    wif.wr_ready = 1'b0;
    tick(1);
    g = got_q.size();
    tick(10);
    chk("hold_valid", wif.wr_valid, 1'b1);
    chk("hold_count", got_q.size(), g);
    chk("hold_word", word_t'({wif.wr_row, wif.wr_col, wif.wr_plane, wif.wr_data}), exp_q[g]);
    latch(4'd9, 1'b1, 1'b0);
    wif.wr_ready = 1'b1;
    check_words("overrun");
    clear();

    // Reset in the middle of a drain
    send_row(4'd2, 64, 1'b1);
    t = 0;
    while (!(wif.wr_valid === 1'b1 && wif.wr_col === 6'd30) && t < 300) begin
      tick(1);
      t++;
    end
    chk("col30_reached", 32'(t < 300), 32'd1);
    chk("pre_reset_words", got_q.size(), 33);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("pre_reset_word%0d", i), got_q[i], exp_q[i]);
    reset = 1'b1;
    tick(1);
    chk_idle_outputs("mid_reset");
    reset = 1'b0;
    model_reset();
    tick(1);
    send_row(4'd2, 64, 1'b1);
    check_words("post_reset");

`ifdef MATRIX_RX_OE_MEASURE_EN
    hub_oe = 1'b1;
    tick(32);
    hub_oe = 1'b0;
    tick(5);
    chk("oe_32", oe_cycles, 16'd32);
    hub_oe = 1'b1;
    tick(70000);
    hub_oe = 1'b0;
    tick(5);
    chk("oe_sat", oe_cycles, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
